inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 23 ++
 rtl/inst_fetch_if_id.sv | 40 ++++
 rtl/inst_fetch.sv | 68 ++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, reset/chip-enable levels,
// reset vector and the fetch FSM state type.
package inst_fetch_pkg;

    localparam int          INST_ADDR_BUS = 32;
    localparam int          INST_BUS      = 32;
    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic        CHIP_ENABLE   = 1'b1;
    localparam logic        CHIP_DISABLE  = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [INST_ADDR_BUS-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic {
        ST_WAIT  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_t;

    // Loaded PCs are always word aligned; the low two bits are dropped.
    function automatic logic [INST_ADDR_BUS-1:0] align_pc(input logic [INST_ADDR_BUS-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/inst_fetch_if_id.sv
// IF/ID pipeline register: holds the instruction handed to decode along
// with its PC and a valid bit, and applies flush / hold / bubble rules.
import inst_fetch_pkg::*;

module if_id (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    input  logic                     flush,
    input  logic                     stall_if,
    input  logic                     stall_id,
    input  logic [INST_ADDR_BUS-1:0] if_pc,
    input  logic [INST_BUS-1:0]      if_inst,
    output logic [INST_ADDR_BUS-1:0] id_pc,
    output logic [INST_BUS-1:0]      id_inst,
    output logic                     id_valid
);

    // Flush beats everything; any stall_id holds; stall_if alone injects a bubble.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || !fetch_en || flush) begin
            id_pc    <= ZERO_WORD;
            id_inst  <= ZERO_WORD;
            id_valid <= 1'b0;
        end else if (stall_id) begin
            id_pc    <= id_pc;
            id_inst  <= id_inst;
            id_valid <= id_valid;
        end else if (stall_if) begin
            id_pc    <= ZERO_WORD;
            id_inst  <= ZERO_WORD;
            id_valid <= 1'b0;
        end else begin
            id_pc    <= if_pc;
            id_inst  <= if_inst;
            id_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: WAIT/FETCH state, PC register driving the ROM,
// and the IF/ID register presenting fetched words to decode.
import inst_fetch_pkg::*;

module inst_fetch (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_if,
    input  logic                     stall_id,
    input  logic                     flush,
    input  logic [INST_ADDR_BUS-1:0] new_pc,
    input  logic                     branch_flag_i,
    input  logic [INST_ADDR_BUS-1:0] branch_target_address_i,
    input  logic [INST_BUS-1:0]      inst_i,
    output logic                     rom_ce_o,
    output logic [INST_ADDR_BUS-1:0] pc_o,
    output logic [INST_ADDR_BUS-1:0] id_pc_o,
    output logic [INST_BUS-1:0]      id_inst_o,
    output logic                     id_valid_o
);

    fetch_state_t state;

    // State, chip enable and PC are all registered so the ROM address has
    // no combinational path from any input.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state    <= ST_WAIT;
            rom_ce_o <= CHIP_DISABLE;
            pc_o     <= RESET_VECTOR;
        end else begin
            case (state)
                ST_WAIT: begin
                    state    <= ST_FETCH;
                    rom_ce_o <= CHIP_ENABLE;
                    pc_o     <= RESET_VECTOR;
                end
                default: begin
                    state    <= ST_FETCH;
                    rom_ce_o <= CHIP_ENABLE;
                    if (flush)
                        pc_o <= align_pc(new_pc);
                    else if (stall_if || stall_id)
                        pc_o <= pc_o;
                    else if (branch_flag_i)
                        pc_o <= align_pc(branch_target_address_i);
                    else
                        pc_o <= pc_o + 32'd4;
                end
            endcase
        end
    end

    if_id u_if_id (
        .clk      (clk),
        .rst      (rst),
        .fetch_en (state == ST_FETCH),
        .flush    (flush),
        .stall_if (stall_if),
        .stall_id (stall_id),
        .if_pc    (pc_o),
        .if_inst  (inst_i),
        .id_pc    (id_pc_o),
        .id_inst  (id_inst_o),
        .id_valid (id_valid_o)
    );

endmodule
